// File: rtl/gshare_predictor.sv
// gshare direction predictor: global history XOR-folded into a table of
// saturating counters, with registered predictions and mispredict recovery.
module gshare_predictor #(
  parameter int CTR_WIDTH  = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int GHR_WIDTH  = 8,
  parameter int CTR_INIT   = 2**(CTR_WIDTH-1)-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic                  pred_out_valid,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_index,
  output logic [GHR_WIDTH-1:0]  pred_ghr,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [GHR_WIDTH-1:0]  upd_ghr
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [CTR_WIDTH-1:0]  table_q [DEPTH];
  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d, ghr_shift, ghr_recover;
  logic [ADDR_WIDTH-1:0] lk_idx;
  logic [CTR_WIDTH-1:0]  upd_cur, upd_new, lk_ctr;
  logic                  predicted;

  logic                  out_valid_q, out_taken_q;
  logic [ADDR_WIDTH-1:0] out_index_q;
  logic [GHR_WIDTH-1:0]  out_ghr_q;

  assign lk_idx = pred_pc ^ ADDR_WIDTH'(ghr_q);

  always_comb begin
    upd_cur = table_q[upd_index];
    upd_new = upd_cur;
    if (upd_taken) begin
      if (!(&upd_cur)) upd_new = upd_cur + CTR_WIDTH'(1);
    end else begin
      if (|upd_cur) upd_new = upd_cur - CTR_WIDTH'(1);
    end
  end

  // Write-first: a same-cycle update to the looked-up entry is visible to the lookup.
  always_comb begin
    lk_ctr = table_q[lk_idx];
    if (upd_valid && (upd_index == lk_idx)) lk_ctr = upd_new;
  end

  assign predicted = lk_ctr[CTR_WIDTH-1];

  if (GHR_WIDTH == 1) begin : g_ghr_one
    assign ghr_shift   = predicted;
    assign ghr_recover = upd_taken;
  end else begin : g_ghr_multi
    assign ghr_shift   = {ghr_q[GHR_WIDTH-2:0], predicted};
    assign ghr_recover = {upd_ghr[GHR_WIDTH-2:0], upd_taken};
  end

  // Recovery wins over a same-cycle speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) ghr_d = ghr_recover;
    else if (pred_valid)             ghr_d = ghr_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= CTR_WIDTH'(CTR_INIT);
    end else if (upd_valid) begin
      table_q[upd_index] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q       <= '0;
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      out_index_q <= '0;
      out_ghr_q   <= '0;
    end else begin
      ghr_q       <= ghr_d;
      out_valid_q <= pred_valid;
      if (pred_valid) begin
        out_taken_q <= predicted;
        out_index_q <= lk_idx;
        out_ghr_q   <= ghr_q;
      end
    end
  end

  assign pred_out_valid = out_valid_q;
  assign pred_taken     = out_taken_q;
  assign pred_index     = out_index_q;
  assign pred_ghr       = out_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed vector bench for gshare_predictor at default parameters.
module tb_gshare_predictor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pred_valid = 1'b0;
  logic [7:0] pred_pc = '0;
  logic       pred_out_valid, pred_taken;
  logic [7:0] pred_index, pred_ghr;
  logic       upd_valid = 1'b0;
  logic [7:0] upd_index = '0;
  logic       upd_taken = 1'b0;
  logic       upd_mispredict = 1'b0;
  logic [7:0] upd_ghr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.CTR_WIDTH(2), .ADDR_WIDTH(8), .GHR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_index(pred_index), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr)
  );

  typedef struct packed {
    logic       pv;
    logic [7:0] pc;
    logic       uv;
    logic [7:0] uidx;
    logic       ut;
    logic       um;
    logic [7:0] ughr;
    logic       e_ov;
    logic       e_t;
    logic [7:0] e_idx;
    logic [7:0] e_ghr;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic ov, input logic t,
                       input logic [7:0] idx, input logic [7:0] ghr);
    checks++;
    if ({pred_out_valid, pred_taken, pred_index, pred_ghr} !== {ov, t, idx, ghr}) begin
      errors++;
      $display("FAIL %s: got ov=%b t=%b idx=%h ghr=%h, expected ov=%b t=%b idx=%h ghr=%h",
               name, pred_out_valid, pred_taken, pred_index, pred_ghr, ov, t, idx, ghr);
    end
  endtask

  task automatic drive(input vec_t v);
    pred_valid = v.pv; pred_pc = v.pc;
    upd_valid = v.uv; upd_index = v.uidx; upd_taken = v.ut;
    upd_mispredict = v.um; upd_ghr = v.ughr;
  endtask

  task automatic idle();
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    //                pv  pc    uv  uidx  ut  um  ughr   ov  t   idx    ghr
    vq.push_back('{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00});
    repeat (4)
      vq.push_back('{1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h00});
    vq.push_back('{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 8'h00});
    vq.push_back('{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 8'h01});
    repeat (5)
      vq.push_back('{1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 8'h01});
    vq.push_back('{1'b1, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'h02});
    // recovery to ghr=0, then train 0x20/0x21/0x23 weakly taken
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h05, 8'h02});
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h02});
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'h21, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h02});
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'h23, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h02});
    vq.push_back('{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h00});
    vq.push_back('{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 8'h01});
    vq.push_back('{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h23, 8'h03});
    vq.push_back('{1'b1, 8'h30, 1'b1, 8'hFE, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h37, 8'h07});
    vq.push_back('{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h34, 8'h04});
    // mispredict without upd_valid must not touch ghr or counters
    vq.push_back('{1'b1, 8'h30, 1'b0, 8'h38, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h38, 8'h08});
    vq.push_back('{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h10});
    // same-cycle bypass on 0x10, then confirm counter is exactly 2
    vq.push_back('{1'b1, 8'h31, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h21});
    vq.push_back('{1'b1, 8'h53, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h43});
    vq.push_back('{1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h43});
    vq.push_back('{1'b1, 8'h97, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h87});

    #12;
    check("reset_outputs", 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].e_ov, vq[i].e_t, vq[i].e_idx, vq[i].e_ghr);
    end

    // Async reset between edges with a prediction in flight
    idle();
    pred_valid = 1'b1; pred_pc = 8'h00;
    @(posedge clk);
    #1;
    check("pre_reset_lookup", 1'b1, 1'b0, 8'h0E, 8'h0E);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pred_valid = 1'b1; pred_pc = 8'h20;
    @(posedge clk);
    #1;
    check("post_reset_ctr_init", 1'b1, 1'b0, 8'h20, 8'h00);
    pred_pc = 8'h05;
    @(posedge clk);
    #1;
    check("post_reset_idx05", 1'b1, 1'b0, 8'h05, 8'h00);
    idle();
    @(posedge clk);
    #1;
    check("valid_drops", 1'b0, 1'b0, 8'h05, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
